// File: rtl/thread_bundle_mux_pkg.sv
// Shared SMT definitions for the bundle gather path: thread count, thread ID width
// and the bit position of each instruction slot inside a 4-slot bundle.
package thread_bundle_mux_pkg;

   localparam int NUM_THREADS = 4;
   localparam int THREAD_ID_W = 2;
   localparam int NUM_SLOTS   = 4;

   typedef logic [THREAD_ID_W-1:0] tid_t;
   typedef logic [NUM_THREADS-1:0] thread_mask_t;

   // Slot 0 (isn1) sits in the MSBs of the bundle.
   function automatic int slot_msb(input int k, input int isn_w);
      return (NUM_SLOTS - k) * isn_w - 1;
   endfunction

endpackage

// File: rtl/thread_bundle_mux_rr_arbiter4.sv
// Combinational 4-way round-robin arbiter: first requester at or after ptr wins.
// The pointer register itself lives in the parent so stalls can freeze it there.
module rr_arbiter4
   import thread_bundle_mux_pkg::*;
(
   input  logic [NUM_THREADS-1:0] req,
   input  logic [THREAD_ID_W-1:0] ptr,
   output logic [NUM_THREADS-1:0] grant,
   output logic [THREAD_ID_W-1:0] grant_id
);

   logic             found;
   logic [THREAD_ID_W-1:0] idx;

   always_comb begin
      grant    = '0;
      grant_id = ptr;
      found    = 1'b0;
      idx      = ptr;
      for (int i = 0; i < NUM_THREADS; i++) begin
         // 2-bit add wraps 3 -> 0 naturally
         idx = ptr + THREAD_ID_W'(i);
         if (!found && req[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = idx;
         end
      end
   end

endmodule

// File: rtl/thread_bundle_mux.sv
// Gathers per-thread 4-instruction bundles into 1-entry buffers and forwards one
// bundle per cycle, round-robin among full buffers, to the shared decode stage.
module thread_bundle_mux
   import thread_bundle_mux_pkg::*;
#(
   parameter int ISN_WIDTH     = 99,
   parameter int ADDRESS_WIDTH = 32
) (
   input  logic                     i_Clk,
   input  logic                     i_Reset_n,
   input  logic                     i_Stall,
   input  logic [NUM_THREADS-1:0]   i_Flush,
   input  logic [4*ISN_WIDTH-1:0]   i_thread1,
   input  logic [4*ISN_WIDTH-1:0]   i_thread2,
   input  logic [4*ISN_WIDTH-1:0]   i_thread3,
   input  logic [4*ISN_WIDTH-1:0]   i_thread4,
   input  logic [NUM_SLOTS-1:0]     i_valid1,
   input  logic [NUM_SLOTS-1:0]     i_valid2,
   input  logic [NUM_SLOTS-1:0]     i_valid3,
   input  logic [NUM_SLOTS-1:0]     i_valid4,
   output logic [NUM_THREADS-1:0]   o_ready,
   output logic [ISN_WIDTH-1:0]     o_Instruction1,
   output logic [ISN_WIDTH-1:0]     o_Instruction2,
   output logic [ISN_WIDTH-1:0]     o_Instruction3,
   output logic [ISN_WIDTH-1:0]     o_Instruction4,
   output logic [NUM_SLOTS-1:0]     o_valid,
   output logic [ADDRESS_WIDTH-1:0] o_thread
);

   localparam int BUNDLE_W = NUM_SLOTS * ISN_WIDTH;

   logic [BUNDLE_W-1:0]  lane_data [NUM_THREADS];
   logic [NUM_SLOTS-1:0] lane_vld  [NUM_THREADS];

   assign lane_data[0] = i_thread1;
   assign lane_data[1] = i_thread2;
   assign lane_data[2] = i_thread3;
   assign lane_data[3] = i_thread4;
   assign lane_vld[0]  = i_valid1;
   assign lane_vld[1]  = i_valid2;
   assign lane_vld[2]  = i_valid3;
   assign lane_vld[3]  = i_valid4;

   thread_mask_t         full_q, full_d;
   tid_t                 rr_ptr_q, rr_ptr_d;
   logic [BUNDLE_W-1:0]  buf_data_q [NUM_THREADS];
   logic [BUNDLE_W-1:0]  buf_data_d [NUM_THREADS];
   logic [NUM_SLOTS-1:0] buf_vld_q  [NUM_THREADS];
   logic [NUM_SLOTS-1:0] buf_vld_d  [NUM_THREADS];

   logic [ISN_WIDTH-1:0] out_isn_q [NUM_SLOTS];
   logic [ISN_WIDTH-1:0] out_isn_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] out_vld_q, out_vld_d;
   tid_t                 out_tid_q, out_tid_d;

   thread_mask_t flush_eff;
   thread_mask_t req;
   thread_mask_t grant;
   thread_mask_t drain;
   thread_mask_t load;
   tid_t         grant_id;
   logic         any_grant;
   logic [BUNDLE_W-1:0] sel_data;

   // Flush is ignored entirely while the pipe is stalled.
   assign flush_eff = i_Stall ? '0 : i_Flush;
   assign req       = full_q & ~flush_eff;

   rr_arbiter4 u_arb (
      .req      (req),
      .ptr      (rr_ptr_q),
      .grant    (grant),
      .grant_id (grant_id)
   );

   assign any_grant = |grant;
   assign drain     = i_Stall ? '0 : grant;
   assign o_ready   = ~full_q | (drain & ~flush_eff);
   assign sel_data  = buf_data_q[grant_id];

   always_comb begin
      load   = '0;
      full_d = '0;
      for (int t = 0; t < NUM_THREADS; t++) begin
         // A flushed lane may look ready while empty, but its load is still blocked
         load[t]      = (|lane_vld[t]) & o_ready[t] & ~flush_eff[t];
         full_d[t]    = load[t] | (full_q[t] & ~drain[t] & ~flush_eff[t]);
         buf_data_d[t] = load[t] ? lane_data[t] : buf_data_q[t];
         buf_vld_d[t]  = load[t] ? lane_vld[t]  : buf_vld_q[t];
      end
   end

   always_comb begin
      rr_ptr_d  = rr_ptr_q;
      out_vld_d = out_vld_q;
      out_tid_d = out_tid_q;
      for (int k = 0; k < NUM_SLOTS; k++) begin
         out_isn_d[k] = out_isn_q[k];
      end
      if (!i_Stall) begin
         if (any_grant) begin
            rr_ptr_d  = grant_id + tid_t'(1);
            out_vld_d = buf_vld_q[grant_id];
            out_tid_d = grant_id;
            for (int k = 0; k < NUM_SLOTS; k++) begin
               out_isn_d[k] = sel_data[slot_msb(k, ISN_WIDTH) -: ISN_WIDTH];
            end
         end else begin
            // Bubble: clear payload, keep the last thread tag
            out_vld_d = '0;
            for (int k = 0; k < NUM_SLOTS; k++) begin
               out_isn_d[k] = '0;
            end
         end
      end
   end

   always_ff @(posedge i_Clk or negedge i_Reset_n) begin
      if (!i_Reset_n) begin
         full_q    <= '0;
         rr_ptr_q  <= '0;
         out_vld_q <= '0;
         out_tid_q <= '0;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            out_isn_q[k] <= '0;
         end
      end else begin
         full_q    <= full_d;
         rr_ptr_q  <= rr_ptr_d;
         out_vld_q <= out_vld_d;
         out_tid_q <= out_tid_d;
         for (int k = 0; k < NUM_SLOTS; k++) begin
            out_isn_q[k] <= out_isn_d[k];
         end
      end
   end

   // Buffer payload is qualified by full_q, so it needs no reset.
   always_ff @(posedge i_Clk) begin
      for (int t = 0; t < NUM_THREADS; t++) begin
         buf_data_q[t] <= buf_data_d[t];
         buf_vld_q[t]  <= buf_vld_d[t];
      end
   end

   assign o_Instruction1 = out_isn_q[0];
   assign o_Instruction2 = out_isn_q[1];
   assign o_Instruction3 = out_isn_q[2];
   assign o_Instruction4 = out_isn_q[3];
   assign o_valid        = out_vld_q;
   assign o_thread       = ADDRESS_WIDTH'(out_tid_q);

endmodule
